alu_op_issuer: RTL and testbench

Sequential initiator for the 2-bit combinational ALU (opcode S[2:0], operands A/B/Cin, 4-bit result Y). It accepts operation commands over a valid/ready handshake, drives the ALU operand and opcode pins, and samples Y after a fixed settle time. It converts the subtraction result to two's complement and returns the result over a second valid/ready handshake. It sits between the command source (sequencer or test controller) and the ALU instance.

---
 rtl/alu_op_issuer.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Sequential initiator for a 2-bit combinational ALU. It accepts one operation
// command at a time and drives the ALU operand and opcode pins from registers.
// After SETTLE_CYCLES clock edges it samples the ALU result. SUB results are
// converted from offset binary to two's complement, and the result is returned
// over a valid/ready response channel.
//
// Parameters
//   SETTLE_CYCLES  clock edges between driving the ALU pins and sampling alu_y
//                  (legal range 1..15)
//
// Build option
//   ALU_CHECK_EN   when defined, a golden ALU model checks every sampled
//                  result. A mismatch raises rsp_err and latches err_sticky.
//                  When undefined, rsp_err and err_sticky are tied to 0.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op, cmd_a, cmd_b,      opcode (000 AND, 001 OR, 010 XOR, 011 NOT A,
//   cmd_cin                    100 ADD, 101 SUB, 110 MUL, 111 A>B), operands
//                              and carry-in
//   alu_a, alu_b, alu_cin,     registered drive to the ALU pins; these hold
//   alu_s                      the last accepted command
//   alu_y                      ALU result input
//   rsp_valid / rsp_ready      response handshake
//   rsp_op, rsp_y, rsp_neg     returned opcode, decoded result, SUB negative
//   rsp_err, err_sticky        checker mismatch and its latched OR
//   done_cnt                   completed responses (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module alu_op_issuer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_a,
   input  logic [1:0] cmd_b,
   input  logic       cmd_cin,
   output logic [1:0] alu_a,
   output logic [1:0] alu_b,
   output logic       alu_cin,
   output logic [2:0] alu_s,
   input  logic [3:0] alu_y,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [2:0] rsp_op,
   output logic [3:0] rsp_y,
   output logic       rsp_neg,
   output logic       rsp_err,
   output logic       err_sticky,
   output logic [7:0] done_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [2:0] OP_SUB   = 3'b101;
   // The counter is loaded with SETTLE_CYCLES-1 on acceptance. Sampling on the
   // edge where it reads 0 puts the sample exactly SETTLE_CYCLES edges later.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] alu_a_q, alu_a_d;
   logic [1:0] alu_b_q, alu_b_d;
   logic       alu_cin_q, alu_cin_d;
   logic [2:0] alu_s_q, alu_s_d;
   logic [2:0] rsp_op_q, rsp_op_d;
   logic [3:0] rsp_y_q, rsp_y_d;
   logic       rsp_neg_q, rsp_neg_d;
   logic       rsp_err_q, rsp_err_d;
   logic       err_sticky_q, err_sticky_d;
   logic [7:0] done_cnt_q, done_cnt_d;
   logic       chk_err;

   // The ALU returns SUB as A+Cin-B+8. Flipping bit 3 removes the +8 offset
   // and gives the signed difference (-3..+4) in 4-bit two's complement.
   function automatic logic signed [3:0] sub_to_twos(input logic [3:0] y_offset);
      return $signed(y_offset ^ 4'b1000);
   endfunction

   function automatic logic [3:0] decode_y(input logic [2:0] op, input logic [3:0] y);
      logic [3:0] r;
      if (op == OP_SUB) begin
         r = sub_to_twos(y);
      end else begin
         r = y;
      end
      return r;
   endfunction

   // In offset binary, bit 3 clear means the difference is below zero.
   function automatic logic decode_neg(input logic [2:0] op, input logic [3:0] y);
      return (op == OP_SUB) && !y[3];
   endfunction

`ifdef ALU_CHECK_EN
   // Reference ALU. It uses the same output encoding as the real ALU: SUB in
   // offset binary, A>B as {000, flag}, and logic ops zero-extended.
   function automatic logic [3:0] golden_y(input logic [2:0] s, input logic [1:0] a,
                                           input logic [1:0] b, input logic cin);
      logic [3:0] r;
      case (s)
         3'b000:  r = {2'b00, a & b};
         3'b001:  r = {2'b00, a | b};
         3'b010:  r = {2'b00, a ^ b};
         3'b011:  r = {2'b00, ~a};
         3'b100:  r = {2'b00, a} + {2'b00, b} + {3'b000, cin};
         3'b101:  r = {2'b00, a} + {3'b000, cin} - {2'b00, b} + 4'd8;
         3'b110:  r = {2'b00, a} * {2'b00, b};
         default: r = {3'b000, (a > b)};
      endcase
      return r;
   endfunction

   assign chk_err = (alu_y != golden_y(alu_s_q, alu_a_q, alu_b_q, alu_cin_q));
`else
   assign chk_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cin_d    = alu_cin_q;
      alu_s_d      = alu_s_q;
      rsp_op_d     = rsp_op_q;
      rsp_y_d      = rsp_y_q;
      rsp_neg_d    = rsp_neg_q;
      rsp_err_d    = rsp_err_q;
      err_sticky_d = err_sticky_q;
      done_cnt_d   = done_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               alu_a_d   = cmd_a;
               alu_b_d   = cmd_b;
               alu_cin_d = cmd_cin;
               alu_s_d   = cmd_op;
               cnt_d     = CNT_LOAD;
               state_d   = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == 4'd0) begin
               rsp_op_d     = alu_s_q;
               rsp_y_d      = decode_y(alu_s_q, alu_y);
               rsp_neg_d    = decode_neg(alu_s_q, alu_y);
               rsp_err_d    = chk_err;
               err_sticky_d = err_sticky_q | chk_err;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            // The rsp_* registers are not written here, so they stay stable
            // under backpressure.
            if (rsp_ready) begin
               done_cnt_d = done_cnt_q + 8'd1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         alu_a_q      <= 2'd0;
         alu_b_q      <= 2'd0;
         alu_cin_q    <= 1'b0;
         alu_s_q      <= 3'd0;
         rsp_op_q     <= 3'd0;
         rsp_y_q      <= 4'd0;
         rsp_neg_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         err_sticky_q <= 1'b0;
         done_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         alu_s_q      <= alu_s_d;
         rsp_op_q     <= rsp_op_d;
         rsp_y_q      <= rsp_y_d;
         rsp_neg_q    <= rsp_neg_d;
         rsp_err_q    <= rsp_err_d;
         err_sticky_q <= err_sticky_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = (state_q == ST_RESP);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign alu_s      = alu_s_q;
   assign rsp_op     = rsp_op_q;
   assign rsp_y      = rsp_y_q;
   assign rsp_neg    = rsp_neg_q;
   assign rsp_err    = rsp_err_q;
   assign err_sticky = err_sticky_q;
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
//
// Testbench for alu_op_issuer. A behavioural ALU answers the issuer's pins,
// with an optional XOR corruption so a wrong answer can be injected.
// Expected responses are queued when a command is accepted and popped when the
// response handshake completes.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

   localparam int S = 3;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] y;
      logic       neg;
      logic       err;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_a;
   logic [1:0] cmd_b;
   logic       cmd_cin;
   logic [1:0] alu_a;
   logic [1:0] alu_b;
   logic       alu_cin;
   logic [2:0] alu_s;
   logic [3:0] alu_y;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [2:0] rsp_op;
   logic [3:0] rsp_y;
   logic       rsp_neg;
   logic       rsp_err;
   logic       err_sticky;
   logic [7:0] done_cnt;

   logic [3:0] corrupt;
   exp_t       sb[$];
   int         total;
   int         bad;
   int         cyc;
   int         last_acc;
   bit         chk_spacing;
   logic       exp_sticky;

   alu_op_issuer #(.SETTLE_CYCLES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_cin    (cmd_cin),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_s      (alu_s),
      .alu_y      (alu_y),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_op     (rsp_op),
      .rsp_y      (rsp_y),
      .rsp_neg    (rsp_neg),
      .rsp_err    (rsp_err),
      .err_sticky (err_sticky),
      .done_cnt   (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] alu_ref(input logic [2:0] s, input logic [1:0] a,
                                          input logic [1:0] b, input logic cin);
      int r;
      case (s)
         3'b000:  r = int'(a & b);
         3'b001:  r = int'(a | b);
         3'b010:  r = int'(a ^ b);
         3'b011:  r = int'(~a);
         3'b100:  r = int'(a) + int'(b) + int'(cin);
         3'b101:  r = int'(a) + int'(cin) - int'(b) + 8;
         3'b110:  r = int'(a) * int'(b);
         default: r = (a > b) ? 1 : 0;
      endcase
      return r[3:0];
   endfunction

   always_comb alu_y = alu_ref(alu_s, alu_a, alu_b, alu_cin) ^ corrupt;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command and collect its response. hold = cycles of rsp_ready=0
   // after rsp_valid rises (with a conflicting command presented meanwhile);
   // early = raise rsp_ready at acceptance, before rsp_valid.
   task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic cin, input int hold, input bit early);
      exp_t       e;
      int         diff;
      int         waitc;
      int         k;
      logic [7:0] dc0;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_cin   = cin;
      cmd_valid = 1'b1;
      waitc = 0;
      while (cmd_ready !== 1'b1 && waitc < 50) begin
         tick();
         waitc++;
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL cmd_ready_timeout got=%b want=1", cmd_ready);
         bad++;
         cmd_valid = 1'b0;
         return;
      end
      e.op = op;
      if (op == 3'b101) begin
         diff  = int'(a) + int'(cin) - int'(b);
         e.y   = diff[3:0];
         e.neg = (diff < 0);
      end else begin
         e.y   = alu_ref(op, a, b, cin) ^ corrupt;
         e.neg = 1'b0;
      end
`ifdef ALU_CHECK_EN
      e.err = (corrupt != 4'd0);
`else
      e.err = 1'b0;
`endif
      sb.push_back(e);
      dc0 = done_cnt;
      if (early) rsp_ready = 1'b1;
      tick();
      k = cyc;
      cmd_valid = 1'b0;
      if (chk_spacing && last_acc >= 0) begin
         total++;
         if (k - last_acc != S + 2) begin
            $display("FAIL spacing got=%0d want=%0d", k - last_acc, S + 2);
            bad++;
         end
      end
      last_acc = k;
      total++;
      if ({alu_s, alu_a, alu_b, alu_cin} !== {op, a, b, cin} || cmd_ready !== 1'b0) begin
         $display("FAIL alu_drive got s=%b a=%b b=%b cin=%b rdy=%b want s=%b a=%b b=%b cin=%b rdy=0",
                  alu_s, alu_a, alu_b, alu_cin, cmd_ready, op, a, b, cin);
         bad++;
      end
      waitc = 0;
      while (rsp_valid !== 1'b1 && waitc < 40) begin
         tick();
         waitc++;
      end
      total++;
      if (rsp_valid !== 1'b1) begin
         $display("FAIL rsp_timeout got=%b want=1", rsp_valid);
         bad++;
         void'(sb.pop_front());
         rsp_ready = 1'b0;
         return;
      end
      total++;
      if (cyc - k != S) begin
         $display("FAIL latency got=%0d want=%0d", cyc - k, S);
         bad++;
      end
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = ~op;
         cmd_a     = ~a;
         cmd_b     = ~b;
         cmd_cin   = ~cin;
         tick();
         total++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
             {alu_s, alu_a, alu_b, alu_cin} !== {op, a, b, cin} ||
             rsp_op !== e.op || rsp_y !== e.y || rsp_neg !== e.neg) begin
            $display("FAIL hold got vld=%b rdy=%b s=%b y=%b want vld=1 rdy=0 s=%b y=%b",
                     rsp_valid, cmd_ready, alu_s, rsp_y, op, e.y);
            bad++;
         end
      end
      cmd_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if (rsp_op !== e.op || rsp_y !== e.y || rsp_neg !== e.neg || rsp_err !== e.err) begin
         $display("FAIL rsp got op=%b y=%b neg=%b err=%b want op=%b y=%b neg=%b err=%b",
                  rsp_op, rsp_y, rsp_neg, rsp_err, e.op, e.y, e.neg, e.err);
         bad++;
      end
      exp_sticky = exp_sticky | e.err;
      total++;
      if (err_sticky !== exp_sticky) begin
         $display("FAIL err_sticky got=%b want=%b", err_sticky, exp_sticky);
         bad++;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = early;
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         $display("FAIL post_handshake got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, cmd_ready);
         bad++;
      end
      total++;
      if (done_cnt !== dc0 + 8'd1) begin
         $display("FAIL done_cnt got=%0d want=%0d", done_cnt, dc0 + 8'd1);
         bad++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      total++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 2'd0 || alu_b !== 2'd0 ||
          alu_cin !== 1'b0 || alu_s !== 3'd0 || rsp_op !== 3'd0 || rsp_y !== 4'd0 ||
          rsp_neg !== 1'b0 || rsp_err !== 1'b0 || err_sticky !== 1'b0 || done_cnt !== 8'd0) begin
         $display("FAIL %s got rdy=%b vld=%b a=%b b=%b cin=%b s=%b op=%b y=%b neg=%b err=%b stk=%b cnt=%0d want rdy=1 rest 0",
                  tag, cmd_ready, rsp_valid, alu_a, alu_b, alu_cin, alu_s, rsp_op, rsp_y,
                  rsp_neg, rsp_err, err_sticky, done_cnt);
         bad++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      check_reset_values("reset_state");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_values("after_release");
   endtask

   task automatic test_add();
      corrupt = 4'd0;
      issue(3'b100, 2'd3, 2'd2, 1'b1, 0, 1'b0);
      issue(3'b100, 2'd0, 2'd0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_logic();
      logic [2:0] ops [5];
      ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b011; ops[4] = 3'b111;
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 0, 1'b0);
      end
      issue(3'b111, 2'd2, 2'd1, 1'b0, 0, 1'b0);
      issue(3'b111, 2'd1, 2'd1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_sub();
      issue(3'b101, 2'd1, 2'd3, 1'b0, 0, 1'b0);
      issue(3'b101, 2'd3, 2'd1, 1'b1, 0, 1'b0);
      issue(3'b101, 2'd0, 2'd3, 1'b0, 0, 1'b0);
      issue(3'b101, 2'd3, 2'd0, 1'b1, 0, 1'b0);
      issue(3'b101, 2'd2, 2'd2, 1'b0, 0, 1'b0);
   endtask

   task automatic test_checker();
      corrupt = 4'b0001;
      issue(3'b110, 2'd3, 2'd3, 1'b0, 0, 1'b0);
      corrupt = 4'd0;
      issue(3'b100, 2'd1, 2'd1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      issue(3'b100, 2'd2, 2'd1, 1'b0, 5, 1'b0);
      issue(3'b101, 2'd0, 2'd1, 1'b1, 2, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit seen;
      cmd_op    = 3'b110;
      cmd_a     = 2'd2;
      cmd_b     = 2'd3;
      cmd_cin   = 1'b1;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_sticky = 1'b0;
      check_reset_values("reset_mid");
      tick();
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < S + 4; i++) begin
         tick();
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen || done_cnt !== 8'd0) begin
         $display("FAIL discard got seen=%b cnt=%0d want seen=0 cnt=0", seen, done_cnt);
         bad++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] dc_start;
      dc_start    = done_cnt;
      chk_spacing = 1'b1;
      last_acc    = -1;
      for (int i = 0; i < 256; i++) begin
         issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 0, 1'b1);
      end
      chk_spacing = 1'b0;
      rsp_ready   = 1'b0;
      total++;
      if (done_cnt !== dc_start) begin
         $display("FAIL wrap got=%0d want=%0d", done_cnt, dc_start);
         bad++;
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 3'd0;
      cmd_a       = 2'd0;
      cmd_b       = 2'd0;
      cmd_cin     = 1'b0;
      rsp_ready   = 1'b0;
      corrupt     = 4'd0;
      last_acc    = -1;
      chk_spacing = 1'b0;
      exp_sticky  = 1'b0;
      test_reset();
      test_add();
      test_logic();
      test_sub();
      test_checker();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
